// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and helpers for the memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam int unsigned MEM_ARB_AW = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic        err;
   } arb_req_t;

   // Misaligned, or any byte-address bit above the word-address field set.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
      return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational tie-break between fetch and data requests.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       if_req_i,
   input  logic       dm_req_i,
   input  arb_owner_t last_i,
   output arb_owner_t winner_o
);

   always_comb begin
      winner_o = OWN_IF;
      if (dm_req_i && (!if_req_i || last_i == OWN_IF)) begin
         winner_o = OWN_DM;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Fetch/data arbiter for a single-port synchronous memory with
//                address range checks. MEM_ARB_RR_EN selects round-robin ties.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW = MEM_ARB_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_ready,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   output logic          if_err,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [31:0]   dm_addr,
   input  logic [31:0]   dm_wdata,
   output logic          dm_ready,
   output logic          dm_rvalid,
   output logic [31:0]   dm_rdata,
   output logic          dm_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rden,
   output logic          mem_wren,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_q
);

   arb_state_t    state_q;
   arb_owner_t    owner_q;
   logic          we_q;
   logic          err_q;
   logic [AW-1:0] mem_addr_q;
   logic [31:0]   mem_wdata_q;
   logic          mem_rden_q;
   logic          mem_wren_q;

   arb_owner_t    w_last;
   arb_owner_t    w_win;
   arb_req_t      w_sel;
   logic          w_any;
   logic          w_grant;
   logic [31:0]   w_rd;

   // The latched owner doubles as the grant history; it resets to "fetch last".
`ifdef MEM_ARB_RR_EN
   assign w_last = owner_q;
`else
   assign w_last = OWN_IF;
`endif

   mem_arb_pick u_pick (
      .if_req_i (if_req),
      .dm_req_i (dm_req),
      .last_i   (w_last),
      .winner_o (w_win)
   );

   assign w_any   = if_req | dm_req;
   assign w_grant = rst_n && (state_q == IDLE) && w_any;

   always_comb begin
      w_sel = '0;
      if (w_win == OWN_DM) begin
         w_sel.addr  = dm_addr;
         w_sel.we    = dm_we;
         w_sel.wdata = dm_wdata;
      end else begin
         w_sel.addr  = if_addr;
      end
      w_sel.err = addr_err(w_sel.addr, AW);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rden_q  <= 1'b0;
         mem_wren_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_any) begin
                  state_q     <= ACCESS;
                  owner_q     <= w_win;
                  we_q        <= w_sel.we;
                  err_q       <= w_sel.err;
                  mem_addr_q  <= w_sel.addr[AW+1:2];
                  mem_wdata_q <= w_sel.wdata;
                  mem_rden_q  <= !w_sel.we && !w_sel.err;
                  mem_wren_q  <= w_sel.we && !w_sel.err;
               end
            end
            ACCESS: begin
               state_q    <= RESP;
               mem_rden_q <= 1'b0;
               mem_wren_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               mem_rden_q <= 1'b0;
               mem_wren_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rden  = mem_rden_q;
   assign mem_wren  = mem_wren_q;

   assign if_ready  = w_grant && (w_win == OWN_IF);
   assign dm_ready  = w_grant && (w_win == OWN_DM);

   assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
   assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);

   assign w_rd      = (!we_q && !err_q) ? mem_q : 32'd0;
   assign if_rdata  = if_rvalid ? w_rd : 32'd0;
   assign dm_rdata  = dm_rvalid ? w_rd : 32'd0;
   assign if_err    = if_rvalid && err_q;
   assign dm_err    = dm_rvalid && err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed vector bench for mem_port_arbiter with a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int unsigned AW = 10;

   logic          clk;
   logic          rst_n;
   logic          if_req;
   logic [31:0]   if_addr;
   logic          if_ready, if_rvalid, if_err;
   logic [31:0]   if_rdata;
   logic          dm_req, dm_we;
   logic [31:0]   dm_addr, dm_wdata;
   logic          dm_ready, dm_rvalid, dm_err;
   logic [31:0]   dm_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_rden, mem_wren;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_q;

   logic [31:0]   mem [0:(1<<AW)-1];

   int n_applied = 0;
   int n_miss    = 0;

   mem_port_arbiter #(.AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ready  (dm_ready),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .dm_err    (dm_err),
      .mem_addr  (mem_addr),
      .mem_rden  (mem_rden),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_q     (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port memory: read data appears the cycle after rden.
   always @(posedge clk) begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= mem[mem_addr];
   end

   typedef struct {
      logic          if_req;
      logic [31:0]   if_addr;
      logic          dm_req;
      logic          dm_we;
      logic [31:0]   dm_addr;
      logic [31:0]   dm_wdata;
      logic          exp_dm;
      logic [AW-1:0] exp_maddr;
      logic          exp_rden;
      logic          exp_wren;
      logic [31:0]   exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic all_zero(input string name);
      chk({name, "_ctl"}, {22'd0, if_ready, if_rvalid, if_err, dm_ready, dm_rvalid, dm_err,
                           mem_rden, mem_wren, 2'b00}, 32'd0);
      chk({name, "_if_rdata"}, if_rdata, 32'd0);
      chk({name, "_dm_rdata"}, dm_rdata, 32'd0);
      chk({name, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
      chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   // Called #1 after a rising edge with the DUT in IDLE; returns the same way.
   task automatic apply(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      if_req = v.if_req; if_addr = v.if_addr;
      dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
      #1;
      chk({tag, "_ready"}, {30'd0, if_ready, dm_ready}, {30'd0, !v.exp_dm, v.exp_dm});
      @(posedge clk); #1;
      if_req = 1'b0; dm_req = 1'b0;
      #1;
      chk({tag, "_access_en"}, {30'd0, mem_rden, mem_wren}, {30'd0, v.exp_rden, v.exp_wren});
      chk({tag, "_access_addr"}, {22'd0, mem_addr}, {22'd0, v.exp_maddr});
      if (v.exp_wren) chk({tag, "_access_wdata"}, mem_wdata, v.dm_wdata);
      chk({tag, "_access_hs"}, {28'd0, if_ready, dm_ready, if_rvalid, dm_rvalid}, 32'd0);
      @(posedge clk); #1;
      chk({tag, "_resp_vld"}, {28'd0, if_rvalid, if_err, dm_rvalid, dm_err},
          {28'd0, !v.exp_dm, !v.exp_dm && v.exp_err, v.exp_dm, v.exp_dm && v.exp_err});
      chk({tag, "_resp_rdata"}, v.exp_dm ? dm_rdata : if_rdata, v.exp_rdata);
      chk({tag, "_resp_other"}, v.exp_dm ? if_rdata : dm_rdata, 32'd0);
      chk({tag, "_resp_en"}, {30'd0, mem_rden, mem_wren}, 32'd0);
      @(posedge clk); #1;
   endtask

   logic exp_tie [4];

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | i;
      mem[4] = 32'hDEAD_BEEF;
      mem_q  = 32'd0;

      //        ifr  if_addr        dmr  we   dm_addr        dm_wdata       dm  maddr    rd   wr   rdata          err
      vt[0]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 10'd4,   1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vt[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 10'd8,   1'b0, 1'b1, 32'h0,         1'b0};
      vt[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 10'd8,   1'b1, 1'b0, 32'h1234_5678, 1'b0};
      vt[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0002, 32'h0,         1'b1, 10'd0,   1'b0, 1'b0, 32'h0,         1'b1};
      vt[4]  = '{1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 10'd0,   1'b0, 1'b0, 32'h0,         1'b1};
      vt[5]  = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 10'h3FF, 1'b1, 1'b0, 32'hA500_03FF, 1'b0};
      vt[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 10'h3FF, 1'b0, 1'b1, 32'h0,         1'b0};
      vt[7]  = '{1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 10'h3FF, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0};
      vt[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0021, 32'hBAD0_BAD0, 1'b1, 10'd8,   1'b0, 1'b0, 32'h0,         1'b1};
      vt[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 10'd8,   1'b1, 1'b0, 32'h1234_5678, 1'b0};
      vt[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0040, 32'h5555_AAAA, 1'b1, 10'd16,  1'b0, 1'b0, 32'h0,         1'b1};
      vt[11] = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 10'd1,   1'b1, 1'b0, 32'hA500_0001, 1'b0};

`ifdef MEM_ARB_RR_EN
      exp_tie = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_tie = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

      rst_n = 1'b0;
      if_req = 1'b0; if_addr = 32'h0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) apply(vt[i], i);

      // Both requesters held through four transactions; last grant was fetch.
      if_req = 1'b1; if_addr = 32'h0000_0010;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0020; dm_wdata = 32'h0;
      for (int t = 0; t < 4; t++) begin
         #1;
         chk($sformatf("tie%0d_ready", t), {30'd0, if_ready, dm_ready},
             {30'd0, !exp_tie[t], exp_tie[t]});
         @(posedge clk); #1;
         chk($sformatf("tie%0d_access_ready", t), {30'd0, if_ready, dm_ready}, 32'd0);
         @(posedge clk); #1;
         chk($sformatf("tie%0d_resp", t), {28'd0, if_ready, dm_ready, if_rvalid, dm_rvalid},
             {28'd0, 1'b0, 1'b0, !exp_tie[t], exp_tie[t]});
         chk($sformatf("tie%0d_rdata", t), exp_tie[t] ? dm_rdata : if_rdata,
             exp_tie[t] ? 32'h1234_5678 : 32'hDEAD_BEEF);
         @(posedge clk);
      end
      #1;
      if_req = 1'b0; dm_req = 1'b0;
      @(posedge clk); #1;

      // Reset asserted while a store is in its ACCESS cycle.
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'h7777_0000;
      #1;
      chk("rst_store_ready", {31'd0, dm_ready}, 32'd1);
      @(posedge clk); #1;
      dm_req = 1'b0;
      chk("rst_store_wren", {31'd0, mem_wren}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      all_zero("rst_async");
      @(posedge clk); #1;
      all_zero("rst_held");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_no_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
      apply(vt[0], 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
